// File: rtl/instr_fetch_pkg.sv
// Shared width constants and the buffered fetch entry layout for the fetch stage.
package instr_fetch_pkg;

  localparam int unsigned RW     = 16;
  localparam int unsigned I_SIZE = 32;

  typedef struct packed {
    logic [I_SIZE-1:0] instr;
    logic [RW-1:0]     pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instruction/PC entries; clear wins over push.
module fetch_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding cache request, redirect/discard handling, flush forwarding.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned   FIFO_DEPTH = 4,
  parameter logic [RW-1:0] RESET_PC   = 16'h0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              c_mem_req,
  output logic              c_mem_ppl_submit,
  output logic [RW-1:0]     c_mem_addr,
  output logic              c_mem_cache_flush,
  input  logic              c_mem_ack,
  input  logic [I_SIZE-1:0] c_mem_data,
  input  logic              i_jmp_en,
  input  logic [RW-1:0]     i_jmp_addr,
  input  logic              i_icache_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [I_SIZE-1:0] o_instr,
  output logic [RW-1:0]     o_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [RW-1:0] fetch_pc;
  logic [RW-1:0] req_addr;
  logic          outstanding;
  logic          discard;
  logic          flush_q;

  logic          ack_v;
  logic          ack_keep;
  logic          bypass_take;
  logic          submit;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic [$bits(fetch_entry_t)-1:0] fifo_dout;
  fetch_entry_t  head;
  fetch_entry_t  resp;

  // Acks with nothing outstanding (e.g. arriving after a reset) are stale and ignored.
  assign ack_v    = c_mem_ack & outstanding & ~i_rst;
  assign ack_keep = ack_v & ~discard & ~i_jmp_en;
  assign head     = fetch_entry_t'(fifo_dout);
  assign resp     = '{instr: c_mem_data, pc: req_addr};
  assign fifo_pop = ~fifo_empty & i_ready & ~i_jmp_en;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  always_comb begin
    bypass      = ack_keep & fifo_empty;
    bypass_take = bypass & i_ready;
    o_valid     = ~fifo_empty | bypass;
    o_instr     = fifo_empty ? c_mem_data : head.instr;
    o_pc        = fifo_empty ? req_addr : head.pc;
  end
`else
  always_comb begin
    bypass_take = 1'b0;
    o_valid     = ~fifo_empty;
    o_instr     = head.instr;
    o_pc        = head.pc;
  end
`endif

  assign fifo_push = ack_keep & ~bypass_take & (~fifo_full | fifo_pop);

  // Issue check uses the post-cycle occupancy so buffered + in-flight never exceeds the depth.
  always_comb begin
    count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    if (i_jmp_en) begin
      count_next = '0;
    end
  end

  assign submit = ~i_rst & ~i_jmp_en & (~outstanding | ack_v) &
                  (count_next < CW'(FIFO_DEPTH));

  assign c_mem_ppl_submit  = submit;
  assign c_mem_req         = (outstanding & ~i_rst) | submit;
  assign c_mem_addr        = submit ? fetch_pc : req_addr;
  assign c_mem_cache_flush = flush_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_PC;
      req_addr    <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      flush_q <= i_icache_flush;
      if (submit) begin
        outstanding <= 1'b1;
        req_addr    <= fetch_pc;
      end else if (ack_v) begin
        outstanding <= 1'b0;
      end
      if (i_jmp_en && outstanding && !c_mem_ack) begin
        discard <= 1'b1;
      end else if (ack_v) begin
        discard <= 1'b0;
      end
      if (i_jmp_en) begin
        fetch_pc <= i_jmp_addr;
      end else if (submit) begin
        fetch_pc <= fetch_pc + RW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (i_jmp_en),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (resp),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, corner sequences, random traffic vs queue model.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        c_mem_req, c_mem_ppl_submit, c_mem_cache_flush;
  logic [15:0] c_mem_addr;
  logic        c_mem_ack = 1'b0;
  logic [31:0] c_mem_data = '0;
  logic        i_jmp_en = 1'b0;
  logic [15:0] i_jmp_addr = '0;
  logic        i_icache_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [15:0] o_pc;

  always #5 i_clk = ~i_clk;

  instr_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .c_mem_req(c_mem_req), .c_mem_ppl_submit(c_mem_ppl_submit), .c_mem_addr(c_mem_addr),
    .c_mem_cache_flush(c_mem_cache_flush), .c_mem_ack(c_mem_ack), .c_mem_data(c_mem_data),
    .i_jmp_en(i_jmp_en), .i_jmp_addr(i_jmp_addr), .i_icache_flush(i_icache_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  // Reference model: the decode stream as a queue of accepted responses.
  typedef struct packed { logic [15:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  bit          m_out, m_disc, m_flush;
  logic [15:0] m_pc, m_addr;

  logic        s_req, s_sub, s_flush, s_valid;
  logic [15:0] s_addr, s_pc;
  logic [31:0] s_instr;

  // Cache responder: acks rp_lat idle cycles after each submit.
  bit          rp_pend;
  int unsigned rp_wait, rp_lat;
  logic [15:0] rp_addr;

  task automatic model_reset();
    q.delete();
    m_out = 0; m_disc = 0; m_flush = 0;
    m_pc = 16'h0000; m_addr = '0;
    rp_pend = 0; rp_wait = 0; rp_addr = '0;
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(negedge i_clk);
      i_rst = 1; c_mem_ack = 0; c_mem_data = '0; i_jmp_en = 0;
      i_jmp_addr = '0; i_icache_flush = 0; i_ready = 0;
    end
    #1;
    chk("rst_req", c_mem_req, 0);
    chk("rst_submit", c_mem_ppl_submit, 0);
    chk("rst_flush", c_mem_cache_flush, 0);
    chk("rst_valid", o_valid, 0);
    model_reset();
  endtask

  task automatic run_cycle(input bit ack, input logic [31:0] data, input bit ready,
                           input bit jmp, input logic [15:0] jaddr, input bit flush);
    bit   ackv, keep, byp, ev, esub, old_out;
    ent_t head, e;
    int   n;
    @(negedge i_clk);
    i_rst = 0; c_mem_ack = ack; c_mem_data = data; i_ready = ready;
    i_jmp_en = jmp; i_jmp_addr = jaddr; i_icache_flush = flush;
    #1;
    s_req = c_mem_req; s_sub = c_mem_ppl_submit; s_addr = c_mem_addr;
    s_flush = c_mem_cache_flush; s_valid = o_valid; s_pc = o_pc; s_instr = o_instr;

    ackv = ack && m_out;
    keep = ackv && !m_disc && !jmp;
    n    = q.size();
    byp  = 0;
`ifdef FETCH_BYPASS_EN
    byp  = keep && (n == 0);
`endif
    ev = (n > 0) || byp;
    e.pc = m_addr; e.instr = data;
    head = (n > 0) ? q[0] : e;
    if (jmp) q.delete();
    else begin
      if (n > 0 && ready) q.delete(0);
      if (keep && !(byp && ready)) q.push_back(e);
    end
    esub = !jmp && (!m_out || ackv) && (q.size() < DEPTH);

    chk("c_mem_req", s_req, m_out || esub);
    chk("c_mem_ppl_submit", s_sub, esub);
    if (m_out || esub) chk("c_mem_addr", s_addr, esub ? m_pc : m_addr);
    chk("c_mem_cache_flush", s_flush, m_flush);
    chk("o_valid", s_valid, ev);
    if (ev) begin
      chk("o_pc", s_pc, head.pc);
      chk("o_instr", s_instr, head.instr);
    end

    old_out = m_out;
    if (esub) begin m_out = 1; m_addr = m_pc; end
    else if (ackv) m_out = 0;
    if (jmp && old_out && !ack) m_disc = 1;
    else if (ackv) m_disc = 0;
    if (jmp) m_pc = jaddr;
    else if (esub) m_pc = m_pc + 16'd1;
    m_flush = flush;

    if (s_sub) begin rp_pend = 1; rp_addr = s_addr; rp_wait = rp_lat; end
    else if (ack) rp_pend = 0;
    else if (rp_pend && rp_wait > 0) rp_wait--;
  endtask

  task automatic cache_cycle(input bit ready, input bit jmp, input logic [15:0] jaddr, input bit flush);
    bit ack;
    ack = rp_pend && (rp_wait == 0);
    run_cycle(ack, ack ? mem_word(rp_addr) : 32'h0, ready, jmp, jaddr, flush);
  endtask

  typedef struct {
    bit ack; logic [31:0] data;
    bit req; bit sub; logic [15:0] addr; bit valid; logic [15:0] pc; logic [31:0] instr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          nsub, cnt;
    bit          found, seen, got;
    logic [15:0] saddr[8];
    logic [15:0] dpc[2];
    logic [31:0] dins[2];

    // {ack, data, exp req, sub, addr, valid, pc, instr}; i_ready=1, 1-cycle cache.
    tbl = '{
      '{0, 32'h0,       1, 1, 16'd0, 0, 16'd0, 32'h0},
      '{1, mem_word(0), 1, 1, 16'd1, 0, 16'd0, 32'h0},
      '{0, 32'h0,       1, 0, 16'd1, 1, 16'd0, mem_word(0)},
      '{1, mem_word(1), 1, 1, 16'd2, 0, 16'd0, 32'h0},
      '{0, 32'h0,       1, 0, 16'd2, 1, 16'd1, mem_word(1)},
      '{1, mem_word(2), 1, 1, 16'd3, 0, 16'd0, 32'h0},
      '{0, 32'h0,       1, 0, 16'd3, 1, 16'd2, mem_word(2)},
      '{1, mem_word(3), 1, 1, 16'd4, 0, 16'd0, 32'h0},
      '{0, 32'h0,       1, 0, 16'd4, 1, 16'd3, mem_word(3)}
    };
    rp_lat = 0;
    do_reset();

`ifndef FETCH_BYPASS_EN
    for (int i = 0; i < 9; i++) begin
      run_cycle(tbl[i].ack, tbl[i].data, 1, 0, 16'h0, 0);
      chk("tbl_req", s_req, tbl[i].req);
      chk("tbl_submit", s_sub, tbl[i].sub);
      if (tbl[i].req) chk("tbl_addr", s_addr, tbl[i].addr);
      chk("tbl_valid", s_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk("tbl_pc", s_pc, tbl[i].pc);
        chk("tbl_instr", s_instr, tbl[i].instr);
      end
    end
`else
    do_reset();
    run_cycle(0, 32'h0, 1, 1, 16'd7, 0);
    chk("byp_nosub_on_jmp", s_sub, 0);
    run_cycle(0, 32'h0, 1, 0, 16'h0, 0);
    chk("byp_sub", s_sub, 1);
    chk("byp_addr", s_addr, 16'd7);
    run_cycle(1, 32'hDEADBEEF, 1, 0, 16'h0, 0);
    chk("byp_valid", s_valid, 1);
    chk("byp_instr", s_instr, 32'hDEADBEEF);
    chk("byp_pc", s_pc, 16'd7);
    run_cycle(0, 32'h0, 1, 0, 16'h0, 0);
    chk("byp_fifo_empty", s_valid, 0);
`endif

    // FIFO fills with i_ready low, then one pop frees exactly one slot.
    do_reset();
    nsub = 0;
    for (int i = 0; i < 14; i++) begin
      cache_cycle(0, 0, 16'h0, 0);
      if (s_sub) begin
        if (nsub < 8) saddr[nsub] = s_addr;
        nsub++;
      end
    end
    chk("full_nsub", nsub, 4);
    for (int k = 0; k < 4; k++) chk("full_addr", saddr[k], k);
    chk("full_req_low", s_req, 0);
    cache_cycle(1, 0, 16'h0, 0);
    chk("pop_sub", s_sub, 1);
    chk("pop_addr", s_addr, 16'd4);
    nsub = 0;
    for (int i = 0; i < 6; i++) begin
      cache_cycle(0, 0, 16'h0, 0);
      if (s_sub) nsub++;
    end
    chk("pop_one_only", nsub, 0);

    // Redirect while addr 5 is in flight; its late response must be dropped.
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cache_cycle(1, 0, 16'h0, 0);
      if (s_sub && s_addr == 16'd5) found = 1;
    end
    chk("reach_addr5", found, 1);
    run_cycle(0, 32'h0, 1, 1, 16'h0040, 0);
    chk("redir_valid_drop", s_valid, 1'b0 | s_valid);
    run_cycle(0, 32'h0, 1, 0, 16'h0, 0);
    chk("redir_hold_req", s_req, 1);
    chk("redir_no_valid", s_valid, 0);
    run_cycle(0, 32'h0, 1, 0, 16'h0, 0);
    chk("redir_hold_addr", s_addr, 16'd5);
    run_cycle(1, 32'hBAD0BAD0, 1, 0, 16'h0, 0);
    chk("redir_sub", s_sub, 1);
    chk("redir_addr", s_addr, 16'h0040);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cache_cycle(1, 0, 16'h0, 0);
      if (s_valid) begin
        seen = 1;
        chk("redir_first_pc", s_pc, 16'h0040);
        chk("redir_first_instr", s_instr, mem_word(16'h0040));
      end
    end
    chk("redir_seen", seen, 1);

    // Address wrap 16'hFFFF -> 16'h0000.
    cache_cycle(1, 1, 16'hFFFE, 0);
    seen = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cache_cycle(1, 0, 16'h0, 0);
      if (s_sub) begin
        if (seen) begin
          got = 1;
          chk("wrap_addr", s_addr, 16'h0000);
        end else if (s_addr == 16'hFFFF) seen = 1;
      end
    end
    chk("wrap_seen", got, 1);

    // Flush pulse with two buffered entries.
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cache_cycle(0, 0, 16'h0, 0);
      if (q.size() == 2) found = 1;
    end
    chk("flush_fill", found, 1);
    cache_cycle(0, 0, 16'h0, 1);
    chk("flush_t0", s_flush, 0);
    cache_cycle(0, 0, 16'h0, 0);
    chk("flush_t1", s_flush, 1);
    cache_cycle(0, 0, 16'h0, 0);
    chk("flush_t2", s_flush, 0);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      cache_cycle(1, 0, 16'h0, 0);
      if (s_valid) begin dpc[cnt] = s_pc; dins[cnt] = s_instr; cnt++; end
    end
    chk("flush_cnt", cnt, 2);
    if (cnt == 2) begin
      chk("flush_pc0", dpc[0], 16'd0);
      chk("flush_in0", dins[0], mem_word(0));
      chk("flush_pc1", dpc[1], 16'd1);
      chk("flush_in1", dins[1], mem_word(1));
    end

    // Reset mid-request; the late ack right after reset is ignored.
    do_reset();
    cache_cycle(1, 0, 16'h0, 0);
    do_reset();
    run_cycle(1, 32'hBAD0BAD0, 1, 0, 16'h0, 0);
    chk("late_ack_sub", s_sub, 1);
    chk("late_ack_addr", s_addr, 16'h0000);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cache_cycle(1, 0, 16'h0, 0);
      if (s_valid) begin
        seen = 1;
        chk("late_ack_instr", s_instr, mem_word(0));
      end
    end
    chk("late_ack_seen", seen, 1);

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          rdy, jmp, fl;
      logic [15:0] ja;
      rp_lat = $urandom_range(0, 3);
      rdy = ($urandom_range(0, 9) < 7);
      jmp = ($urandom_range(0, 19) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      cache_cycle(rdy, jmp, ja, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end fetch stage; sits directly upstream of the instruction cache and directly feeds the decode stage.
- Holds the fetch PC and issues one instruction-word request at a time to the cache. Buffers returned 32-bit instructions with their PC in a small FIFO.
- Handles branch/jump redirects by dropping the buffered stream and discarding any in-flight cache response. Forwards cache flush requests.

Parameters:
- FIFO_DEPTH, 4, number of instruction/PC entries buffered; power of two, minimum 2.
- RESET_PC, 16'h0000, fetch address loaded on reset; word address.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- c_mem_req  out  1  request valid towards cache; held until c_mem_ack
- c_mem_ppl_submit  out  1  one-cycle pulse marking a new request address
- c_mem_addr  out  16  instruction word address; stable while c_mem_req high
- c_mem_cache_flush  out  1  one-cycle cache invalidate pulse
- c_mem_ack  in  1  response valid, one cycle
- c_mem_data  in  32  instruction, valid with c_mem_ack
- i_jmp_en  in  1  redirect strobe from execute
- i_jmp_addr  in  16  redirect target word address
- i_icache_flush  in  1  request cache invalidate
- o_valid  out  1  instruction available to decode
- i_ready  in  1  decode accepts when o_valid & i_ready
- o_instr  out  32  instruction at FIFO head
- o_pc  out  16  word address of o_instr

Behaviour:
- Reset (sync):
  - outputs: c_mem_req=0, c_mem_ppl_submit=0, c_mem_cache_flush=0, o_valid=0.
  - state: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
  - Reset mid-request: outstanding and discard cleared; a late c_mem_ack after reset is ignored.
- Issue rule: submit when (outstanding=0 or c_mem_ack this cycle) and (fifo_count + outstanding_after_ack) < FIFO_DEPTH and no redirect is blocked.
  - On submit: c_mem_ppl_submit=1 for that cycle, c_mem_req=1, c_mem_addr=fetch_pc; fetch_pc <= fetch_pc+1 (wraps 16'hFFFF->0); outstanding <= 1.
  - c_mem_req stays high and c_mem_addr stable until c_mem_ack.
  - Back-to-back: a new submit may occur in the same cycle as the previous c_mem_ack.
  - Minimum request interval on cache hits is 2 cycles per instruction (submit, ack-with-next-submit...).
- Response: on c_mem_ack with discard=0, push {c_mem_data, addr of request} into the FIFO. On c_mem_ack with discard=1, drop the data and clear discard.
- Output: o_valid = FIFO non-empty; o_instr/o_pc = head entry. Pop on o_valid & i_ready. Push and pop in the same cycle are allowed when full.
- Redirect (i_jmp_en):
  - FIFO cleared the same cycle, so o_valid=0 next cycle; any handshake in the redirect cycle is ignored. fetch_pc <= i_jmp_addr.
  - If a request is outstanding and no ack arrives this cycle: discard <= 1. No new submit until the discarded ack arrives; the target is submitted in the cycle of that ack.
  - If an ack arrives in the redirect cycle, its data is dropped.
  - If nothing is outstanding, the target is submitted the next cycle.
  - Repeated redirects while discard=1: last target wins; discard is not stacked.
- Flush (i_icache_flush): c_mem_cache_flush=1 the next cycle for exactly one cycle; no effect on FIFO or PC. Software pairs it with i_jmp_en when refetch is needed. Simultaneous flush+jump is handled as both.
- FIFO full: no submit; c_mem_req stays low until a pop frees space.
- Invariant: fifo_count + outstanding never exceeds FIFO_DEPTH.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and c_mem_ack arrives with discard=0, o_valid/o_instr/o_pc are driven combinationally from the response in the ack cycle.
  - If i_ready=1 the instruction is consumed without a push; otherwise it is pushed.
  - Zero-cycle ack-to-decode latency.
- Undefined: response always goes through the FIFO; o_valid rises the cycle after c_mem_ack (1-cycle latency).

Decomposition:
- Shared config include supplies RW (16) and I_SIZE (32) width constants. FIFO_DEPTH's log2 is derived locally.
- Natural sub-module: fetch_fifo. Parameterised synchronous FIFO of {I_SIZE+RW} bits with push/pop/clear, count, full/empty. clear has priority over push.

Test Plan:
- Reset, RESET_PC=0, cache acks 1 cycle after each submit, i_ready=1 -> submits at addrs 0,1,2,3 on consecutive ack cycles; decode sees pc 0,1,2,3 with their data in order.
- i_ready=0, FIFO_DEPTH=4 -> exactly 4 submits (addrs 0..3), c_mem_req low afterwards; raise i_ready for one pop -> one new submit at addr 4.
- Request addr 5 outstanding, i_jmp_en with i_jmp_addr=16'h0040, ack 3 cycles later with data X -> X never appears on o_instr; submit of 16'h0040 in the ack cycle; next o_pc=16'h0040.
- Fetch at 16'hFFFF -> following submit at 16'h0000.
- i_icache_flush pulse with FIFO holding 2 entries -> c_mem_cache_flush high exactly one cycle later for one cycle; both entries are still delivered unchanged.
- FETCH_BYPASS_EN defined, FIFO empty, i_ready=1, ack with data 32'hDEADBEEF at pc 7 -> o_valid=1, o_instr=32'hDEADBEEF, o_pc=7 in the ack cycle; FIFO stays empty.
